// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote,
// false-start rejection, parity/framing/overrun flags and a ready/ready_clr handshake.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk_100m,
   input  logic                 rst,
   input  logic                 clken,
   input  logic                 rx,
   input  logic                 ready_clr,
   output logic                 ready,
   output logic [DATA_BITS-1:0] data,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);
   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int POS_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_PRE       = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] CNT_VOTE      = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(OVERSAMPLE - 1);
   localparam logic [POS_W-1:0] POS_LAST_DATA = POS_W'(DATA_BITS - 1);
   localparam logic [POS_W-1:0] POS_LAST_STOP = POS_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t               state_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [POS_W-1:0]     pos_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 rx_meta_r;
   logic                 rx_s_r;
   logic                 samp_a_r;
   logic                 samp_b_r;
   logic                 par_pend_r;
   logic                 frm_pend_r;
   logic                 vote_s;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
      if (PARITY == 1) begin
         return ~(^word);
      end else begin
         return ^word;
      end
   endfunction

   // Majority of the two stored mid-bit samples and the current one.
   always_comb begin
      vote_s = maj3(samp_a_r, samp_b_r, rx_s_r);
   end

   // Two-flop synchroniser for the asynchronous rx pad.
   always_ff @(posedge clk_100m) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_s_r    <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_s_r    <= rx_meta_r;
      end
   end

   // Frame state machine, sampling and committed outputs.
   always_ff @(posedge clk_100m) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         pos_r      <= '0;
         shift_r    <= '0;
         samp_a_r   <= 1'b1;
         samp_b_r   <= 1'b1;
         par_pend_r <= 1'b0;
         frm_pend_r <= 1'b0;
         ready      <= 1'b0;
         data       <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (ready_clr) ready <= 1'b0;
         if (clken) begin
            if (cnt_r == CNT_PRE) samp_a_r <= rx_s_r;
            if (cnt_r == CNT_MID) samp_b_r <= rx_s_r;
            case (state_r)
               ST_IDLE: begin
                  if (!rx_s_r) begin
                     state_r    <= ST_START;
                     cnt_r      <= '0;
                     par_pend_r <= 1'b0;
                     frm_pend_r <= 1'b0;
                  end
               end
               ST_START: begin
                  if (cnt_r == CNT_VOTE && vote_s) begin
                     state_r <= ST_IDLE;
                     cnt_r   <= '0;
                  end else if (cnt_r == CNT_LAST) begin
                     state_r <= ST_DATA;
                     cnt_r   <= '0;
                     pos_r   <= '0;
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end
               ST_DATA: begin
                  if (cnt_r == CNT_VOTE) shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
                  if (cnt_r == CNT_LAST) begin
                     cnt_r <= '0;
                     if (pos_r == POS_LAST_DATA) begin
                        pos_r   <= '0;
                        state_r <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                     end else begin
                        pos_r <= pos_r + POS_W'(1);
                     end
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end
               ST_PARITY: begin
                  if (cnt_r == CNT_VOTE) par_pend_r <= (vote_s != parity_bit(shift_r));
                  if (cnt_r == CNT_LAST) begin
                     state_r <= ST_STOP;
                     cnt_r   <= '0;
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end
               ST_STOP: begin
                  // Last stop bit commits mid-bit so the next start edge is caught early.
                  if (cnt_r == CNT_VOTE && pos_r == POS_LAST_STOP) begin
                     data       <= shift_r;
                     ready      <= 1'b1;
                     parity_err <= par_pend_r;
                     frame_err  <= frm_pend_r | ~vote_s;
                     overrun    <= ready & ~ready_clr;
                     state_r    <= ST_IDLE;
                     cnt_r      <= '0;
                     pos_r      <= '0;
                  end else begin
                     if (cnt_r == CNT_VOTE && !vote_s) frm_pend_r <= 1'b1;
                     if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        pos_r <= pos_r + POS_W'(1);
                     end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  cnt_r   <= '0;
                  pos_r   <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1/x16 instance and an 8E2/x8 instance driven by serialised
// frames; expectations come from the frame contents and a per-instance handshake model.
`timescale 1ns/1ps
module tb_uart_rx_param;
   localparam int A_OS = 16;
   localparam int B_OS = 8;

   logic       clk_100m = 1'b0;
   logic       rst, clken;
   logic       rx_a, rx_b, ready_clr_a, ready_clr_b;
   logic       ready_a, ready_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;
   logic [7:0] data_a, data_b;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic mdl_ready [2];
   logic obs_pre_rdy, obs_post_rdy;

   always #5 clk_100m = ~clk_100m;

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(A_OS), .PARITY(0), .STOP_BITS(1)) u_dut_a (
      .clk_100m(clk_100m), .rst(rst), .clken(clken), .rx(rx_a), .ready_clr(ready_clr_a),
      .ready(ready_a), .data(data_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a));

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(B_OS), .PARITY(2), .STOP_BITS(2)) u_dut_b (
      .clk_100m(clk_100m), .rst(rst), .clken(clken), .rx(rx_b), .ready_clr(ready_clr_b),
      .ready(ready_b), .data(data_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b));

   // {ready, parity_err, frame_err, overrun, data}
   function automatic logic [11:0] obs(input int sel);
      if (sel == 0) return {ready_a, perr_a, ferr_a, ovr_a, data_a};
      else          return {ready_b, perr_b, ferr_b, ovr_b, data_b};
   endfunction

   task automatic set_rx(input int sel, input logic v);
      if (sel == 0) rx_a = v;
      else          rx_b = v;
   endtask

   // One oversample tick every 4 clocks; optional ready_clr on the tick cycle itself.
   task automatic one_tick(input int sel, input logic clr);
      repeat (3) @(negedge clk_100m);
      clken = 1'b1;
      if (sel == 0) ready_clr_a = clr;
      else          ready_clr_b = clr;
      @(negedge clk_100m);
      clken       = 1'b0;
      ready_clr_a = 1'b0;
      ready_clr_b = 1'b0;
   endtask

   task automatic idle(input int sel, input int n);
      set_rx(sel, 1'b1);
      for (int i = 0; i < n; i++) one_tick(sel, 1'b0);
   endtask

   task automatic ack(input int sel);
      @(negedge clk_100m);
      if (sel == 0) ready_clr_a = 1'b1;
      else          ready_clr_b = 1'b1;
      @(negedge clk_100m);
      ready_clr_a = 1'b0;
      ready_clr_b = 1'b0;
      mdl_ready[sel] = 1'b0;
   endtask

   // Serialise one frame; each bit lasts OVERSAMPLE ticks. Records ready just before and
   // just after the mid-point tick of the last stop bit.
   task automatic send_frame(input int sel, input logic [7:0] word, input logic bad_par,
                             input logic bad_stop, input logic clr_commit,
                             input int glitch_bit, input int abort_after);
      int         os, m, nstop;
      logic       bits [$];
      logic       v;
      logic [11:0] o;
      os    = (sel == 0) ? A_OS : B_OS;
      m     = os / 2;
      nstop = (sel == 0) ? 1 : 2;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(word[i]);
      if (sel == 1) bits.push_back((^word) ^ bad_par);
      for (int s = 0; s < nstop; s++) bits.push_back((s == 0) ? ~bad_stop : 1'b1);
      for (int b = 0; b < bits.size(); b++) begin
         if (b == abort_after) return;
         for (int t = 0; t < os; t++) begin
            v = bits[b];
            if (b == glitch_bit && t == m + 1) v = ~v;
            set_rx(sel, v);
            if (b == bits.size() - 1 && t == m + 2) begin
               o = obs(sel);
               obs_pre_rdy = o[11];
               one_tick(sel, clr_commit);
               o = obs(sel);
               obs_post_rdy = o[11];
            end else begin
               one_tick(sel, 1'b0);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [11:0] o;
      rst = 1'b1; clken = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
      ready_clr_a = 1'b0; ready_clr_b = 1'b0;
      repeat (4) @(negedge clk_100m);
      rst = 1'b0;
      mdl_ready[0] = 1'b0;
      mdl_ready[1] = 1'b0;
      for (int s = 0; s < 2; s++) begin
         o = obs(s);
         n_tests++;
         if (o !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: got %h expected 000", s, o);
         end
      end
   endtask

   task automatic test_basic();
      logic [11:0] o;
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, 99);
      idle(0, 4);
      o = obs(0);
      n_tests++;
      if (o !== {4'b1000, 8'hA5}) begin
         n_fail++;
         $display("FAIL basic_a5: got %h expected %h", o, {4'b1000, 8'hA5});
      end
      n_tests++;
      if (obs_pre_rdy !== 1'b0 || obs_post_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL commit_latency: got pre=%b post=%b expected pre=0 post=1",
                  obs_pre_rdy, obs_post_rdy);
      end
      mdl_ready[0] = 1'b1;
   endtask

   task automatic test_false_start();
      logic [11:0] o;
      ack(0);
      n_tests++;
      if (ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_clr: got %b expected 0", ready_a);
      end
      set_rx(0, 1'b0);
      for (int i = 0; i < 4; i++) one_tick(0, 1'b0);
      idle(0, A_OS + 8);
      n_tests++;
      if (ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL false_start_ready: got %b expected 0", ready_a);
      end
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, 99);
      idle(0, 4);
      o = obs(0);
      n_tests++;
      if (o !== {4'b1000, 8'h3C}) begin
         n_fail++;
         $display("FAIL after_false_start: got %h expected %h", o, {4'b1000, 8'h3C});
      end
      mdl_ready[0] = 1'b1;
   endtask

   task automatic test_parity();
      logic [11:0] o;
      logic [7:0]  w;
      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b0, -1, 99);
      idle(1, 3);
      o = obs(1);
      n_tests++;
      if (o !== {4'b1100, 8'h07}) begin
         n_fail++;
         $display("FAIL parity_err_07: got %h expected %h", o, {4'b1100, 8'h07});
      end
      mdl_ready[1] = 1'b1;
      w = 8'($urandom);
      send_frame(1, w, 1'b0, 1'b0, 1'b0, -1, 99);
      idle(1, 3);
      o = obs(1);
      n_tests++;
      if (o !== {4'b1001, w}) begin
         n_fail++;
         $display("FAIL parity_ok_overrun: got %h expected %h", o, {4'b1001, w});
      end
   endtask

   task automatic test_frame_err();
      logic [11:0] o;
      ack(0);
      send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, -1, 99);
      idle(0, A_OS + 8);
      o = obs(0);
      n_tests++;
      if (o !== {4'b1010, 8'h55}) begin
         n_fail++;
         $display("FAIL frame_err_55: got %h expected %h", o, {4'b1010, 8'h55});
      end
      ack(0);
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, -1, 99);
      idle(0, 4);
      o = obs(0);
      n_tests++;
      if (o !== {4'b1000, 8'h55}) begin
         n_fail++;
         $display("FAIL frame_err_clear: got %h expected %h", o, {4'b1000, 8'h55});
      end
      ack(1);
      send_frame(1, 8'hC3, 1'b0, 1'b1, 1'b0, -1, 99);
      idle(1, 3);
      o = obs(1);
      n_tests++;
      if (o !== {4'b1010, 8'hC3}) begin
         n_fail++;
         $display("FAIL frame_err_first_stop: got %h expected %h", o, {4'b1010, 8'hC3});
      end
      mdl_ready[0] = 1'b1;
      mdl_ready[1] = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [11:0] o;
      ack(0);
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b0, -1, 99);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b0, -1, 99);
      idle(0, 4);
      o = obs(0);
      n_tests++;
      if (o !== {4'b1001, 8'h22}) begin
         n_fail++;
         $display("FAIL b2b_overrun: got %h expected %h", o, {4'b1001, 8'h22});
      end
      ack(0);
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b0, -1, 99);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, -1, 99);
      o = obs(0);
      n_tests++;
      if (o !== {4'b1000, 8'h22} || obs_pre_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_clr_on_commit: got %h pre=%b expected %h pre=1",
                  o, obs_pre_rdy, {4'b1000, 8'h22});
      end
      idle(0, 4);
      mdl_ready[0] = 1'b1;
   endtask

   task automatic test_reset_mid_frame();
      logic [11:0] o;
      send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, -1, 4);
      @(negedge clk_100m);
      rst = 1'b1;
      @(negedge clk_100m);
      rst = 1'b0;
      mdl_ready[0] = 1'b0;
      mdl_ready[1] = 1'b0;
      for (int s = 0; s < 2; s++) begin
         o = obs(s);
         n_tests++;
         if (o !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_frame_reset dut%0d: got %h expected 000", s, o);
         end
      end
      idle(0, A_OS * 8);
      n_tests++;
      if (ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL partial_frame_dropped: got %b expected 0", ready_a);
      end
      send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, 1, 99);
      idle(0, 4);
      o = obs(0);
      n_tests++;
      if (o !== {4'b1000, 8'h81}) begin
         n_fail++;
         $display("FAIL glitch_rejected_81: got %h expected %h", o, {4'b1000, 8'h81});
      end
      mdl_ready[0] = 1'b1;
   endtask

   task automatic test_random();
      int          sel, nbits, gbit, gap;
      logic [7:0]  w;
      logic        bpar, bstop, clr, pre;
      logic [11:0] o, e;
      for (int i = 0; i < 16; i++) begin
         sel   = i % 2;
         nbits = (sel == 0) ? 10 : 12;
         w     = 8'($urandom);
         bpar  = (sel == 1) && ($urandom_range(0, 3) == 0);
         bstop = ($urandom_range(0, 3) == 0);
         clr   = ($urandom_range(0, 3) == 0);
         gbit  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nbits - 1)) : -1;
         if ($urandom_range(0, 1) == 1) ack(sel);
         pre = mdl_ready[sel];
         e   = {1'b1, bpar, bstop, pre & ~clr, w};
         send_frame(sel, w, bpar, bstop, clr, gbit, 99);
         mdl_ready[sel] = 1'b1;
         gap = bstop ? A_OS + 8 : int'($urandom_range(0, 3));
         idle(sel, gap);
         o = obs(sel);
         n_tests++;
         if (o !== e || obs_pre_rdy !== pre) begin
            n_fail++;
            $display("FAIL random_frame %0d dut%0d: got %h pre=%b expected %h pre=%b",
                     i, sel, o, obs_pre_rdy, e, pre);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_parity();
      test_frame_err();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
